mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM for the MIPS subset core. It sequences the fetch unit, instruction register, GRF, ALU and data memory through FETCH/DECODE/EXEC/MEM/WB states, one instruction at a time. It decodes the latched instruction's opcode/funct and drives every write enable and mux select in the datapath. It also keeps a retired-instruction counter for the test bench.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000: reset PC value. The datapath uses it; it is exported here for bench checks only.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `opcode`  in  6  IR[31:26], stable from DECODE until the next FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU equal flag, valid in EXEC.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- `pc_we`  out  1  PC register load.
- `npc_sel`  out  2  next-PC select: 0 = PC+4, 1 = branch (PC + sext(imm)<<2), 2 = {PC[31:28], imm26, 2'b0}, 3 = GPR[rs].
- `ir_we`  out  1  IR load.
- `reg_we`  out  1  GRF write.
- `reg_dst`  out  2  write address: 0 = rt, 1 = rd, 2 = 31.
- `wd_sel`  out  2  write data: 0 = ALU result register, 1 = MDR, 2 = current PC (already PC+4).
- `alu_src`  out  1  ALU operand B: 0 = GPR[rt], 1 = extended immediate.
- `alu_op`  out  3  ALU operation: 0 = add, 1 = sub, 2 = or, 3 = pass B.
- `ext_op`  out  2  immediate extension: 0 = zero-extend, 1 = sign-extend, 2 = imm<<16.
- `mem_we`  out  1  DM write.
- `instr_cnt`  out  32  count of retired instructions.

## Operation
- Decode classes:
  - R-type (opcode 0): funct 0x21 = addu, 0x23 = subu, 0x08 = jr.
  - I-type: ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04.
  - J-type: j 0x02, jal 0x03.
- Anything else, including an all-zero word, is a NOP class.
- All outputs are combinational from `state`, `opcode`, `funct` and `zero`.
- Every output not listed for a state is 0.
- FETCH: `ir_we`=1, `pc_we`=1, `npc_sel`=0. Next state is DECODE.
- DECODE:
  - j: `pc_we`=1, `npc_sel`=2, next FETCH.
  - jal: `pc_we`=1, `npc_sel`=2, `reg_we`=1, `reg_dst`=2, `wd_sel`=2, next FETCH.
  - jr: `pc_we`=1, `npc_sel`=3, next FETCH.
  - NOP class: next FETCH.
  - addu/subu/ori/lui/lw/sw/beq: next EXEC.
- ALU controls are held constant in EXEC, MEM and WB for the current instruction:
  - addu: `alu_op`=0, `alu_src`=0.
  - subu: `alu_op`=1, `alu_src`=0.
  - ori: `alu_op`=2, `alu_src`=1, `ext_op`=0.
  - lui: `alu_op`=3, `alu_src`=1, `ext_op`=2.
  - lw/sw: `alu_op`=0, `alu_src`=1, `ext_op`=1.
  - beq: `alu_op`=1, `alu_src`=0, `ext_op`=1.
- EXEC:
  - beq: `pc_we`=`zero`, `npc_sel`=1, next FETCH.
  - lw/sw: next MEM.
  - addu/subu/ori/lui: next WB.
- MEM:
  - sw: `mem_we`=1, next FETCH.
  - lw: next WB.
- WB:
  - `reg_we`=1, next FETCH.
  - `reg_dst`=1 for addu/subu, 0 otherwise.
  - `wd_sel`=1 for lw, 0 otherwise.
- Retire: `instr_cnt` increments by 1 on every clock edge where the state goes from any non-FETCH state to FETCH. It wraps from 0xFFFF_FFFF to 0.
- Illegal `state` values 5–7: next state is FETCH, all enables are 0, nothing retires.

## Timing
- Reset, on the clock edge where `reset`=1:
  - `state` becomes FETCH and `instr_cnt` becomes 0.
  - While `reset`=1, `pc_we`, `ir_we`, `reg_we` and `mem_we` are forced to 0.
- Reset mid-instruction aborts it: no further writes, no retire count. The first cycle after reset deasserts is FETCH.
- Cycles per instruction, FETCH included:
  - addu/subu/ori/lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, taken or not: 3.
  - j/jal/jr/NOP: 2.
- All register and memory writes take effect at the end of their state's cycle.
- jal writes $31 and loads the PC on the same edge. The written value is the PC as updated by FETCH, i.e. address of jal + 4.
- beq target is relative to PC+4, because the PC was already updated in FETCH.
- `opcode`/`funct` are sampled only in DECODE through WB. Their values during FETCH are don't-care.

## Test plan
- Reset, then `reset`=0 with IR=0x00000000 → states go 0,1,0; `instr_cnt`=1 after 2 cycles; no enable other than FETCH's `pc_we`/`ir_we` pulses.
- lw (opcode 0x23) → states 0,1,2,3,4,0. In WB: `reg_we`=1, `wd_sel`=1, `reg_dst`=0. `mem_we` is never 1. `instr_cnt` +1 after 5 cycles.
- beq with `zero`=1, then with `zero`=0 → EXEC shows `pc_we`=1 then 0, `npc_sel`=1 both times; each instruction takes 3 cycles.
- jal (opcode 0x03) → DECODE shows `pc_we`=1, `npc_sel`=2, `reg_we`=1, `reg_dst`=2, `wd_sel`=2; returns to FETCH in 2 cycles.
- sw, with `reset` asserted during MEM → `mem_we`=0 in that cycle; next state FETCH; `instr_cnt`=0.
- addu, subu, ori, lui back to back → each takes 4 cycles. WB `reg_dst` is 1, 1, 0, 0. EXEC `alu_op` is 0, 1, 2, 3. `instr_cnt`=4.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS subset core.
// Sequences FETCH/DECODE/EXEC/MEM/WB one instruction at a time. It decodes
// opcode/funct into an instruction class and drives every datapath write
// enable and mux select combinationally. It also counts retired instructions.
module mc_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic        mem_we,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_JR   = 4'd3,
    C_ORI  = 4'd4,
    C_LUI  = 4'd5,
    C_LW   = 4'd6,
    C_SW   = 4'd7,
    C_BEQ  = 4'd8,
    C_J    = 4'd9,
    C_JAL  = 4'd10
  } cls_t;

  // The reset PC belongs to the datapath. It must be word aligned, and a
  // misaligned value elaborates an empty, visibly named block.
  if (PC_RESET[1:0] != 2'b00) begin : g_pc_reset_misaligned
  end

  state_t      state_q;
  state_t      state_nxt;
  cls_t        cls;
  logic        retire;

  // Raw (pre-reset-gating) enables produced by the FSM.
  logic        pc_we_c;
  logic        ir_we_c;
  logic        reg_we_c;
  logic        mem_we_c;
  logic [1:0]  npc_sel_c;
  logic [1:0]  reg_dst_c;
  logic [1:0]  wd_sel_c;

  // Classify the latched instruction. Unknown encodings fall into NOP.
  always_comb begin
    cls = C_NOP;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   cls = C_ADDU;
          6'h23:   cls = C_SUBU;
          6'h08:   cls = C_JR;
          default: cls = C_NOP;
        endcase
      end
      6'h0d:   cls = C_ORI;
      6'h0f:   cls = C_LUI;
      6'h23:   cls = C_LW;
      6'h2b:   cls = C_SW;
      6'h04:   cls = C_BEQ;
      6'h02:   cls = C_J;
      6'h03:   cls = C_JAL;
      default: cls = C_NOP;
    endcase
  end

  // ALU controls stay constant across EXEC, MEM and WB, so the ALU result
  // register sees a stable computation for the whole instruction.
  always_comb begin
    alu_op  = 3'd0;
    alu_src = 1'b0;
    ext_op  = 2'd0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls)
        C_ADDU: begin
          alu_op  = 3'd0;
          alu_src = 1'b0;
        end
        C_SUBU: begin
          alu_op  = 3'd1;
          alu_src = 1'b0;
        end
        C_ORI: begin
          alu_op  = 3'd2;
          alu_src = 1'b1;
          ext_op  = 2'd0;
        end
        C_LUI: begin
          alu_op  = 3'd3;
          alu_src = 1'b1;
          ext_op  = 2'd2;
        end
        C_LW, C_SW: begin
          alu_op  = 3'd0;
          alu_src = 1'b1;
          ext_op  = 2'd1;
        end
        C_BEQ: begin
          alu_op  = 3'd1;
          alu_src = 1'b0;
          ext_op  = 2'd1;
        end
        default: begin
          alu_op  = 3'd0;
          alu_src = 1'b0;
          ext_op  = 2'd0;
        end
      endcase
    end
  end

  // Next-state logic and per-state enables/selects. Any state not handled
  // below, including the unused encodings 5-7, returns to FETCH silently.
  always_comb begin
    state_nxt = S_FETCH;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    reg_we_c  = 1'b0;
    mem_we_c  = 1'b0;
    npc_sel_c = 2'd0;
    reg_dst_c = 2'd0;
    wd_sel_c  = 2'd0;
    case (state_q)
      S_FETCH: begin
        ir_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        npc_sel_c = 2'd0;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_J: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'd2;
            state_nxt = S_FETCH;
          end
          C_JAL: begin
            // The PC already holds jal+4 here, so the link value and the
            // jump target are written on the same edge.
            pc_we_c   = 1'b1;
            npc_sel_c = 2'd2;
            reg_we_c  = 1'b1;
            reg_dst_c = 2'd2;
            wd_sel_c  = 2'd2;
            state_nxt = S_FETCH;
          end
          C_JR: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'd3;
            state_nxt = S_FETCH;
          end
          C_NOP:   state_nxt = S_FETCH;
          default: state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_BEQ: begin
            // The branch target is relative to PC+4, which FETCH already
            // loaded into the PC.
            pc_we_c   = zero;
            npc_sel_c = 2'd1;
            state_nxt = S_FETCH;
          end
          C_LW, C_SW:                   state_nxt = S_MEM;
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_nxt = S_WB;
          default:                      state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        case (cls)
          C_SW: begin
            mem_we_c  = 1'b1;
            state_nxt = S_FETCH;
          end
          C_LW:    state_nxt = S_WB;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_WB: begin
        reg_we_c  = 1'b1;
        reg_dst_c = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
        wd_sel_c  = (cls == C_LW) ? 2'd1 : 2'd0;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset blocks every architectural write, so an aborted instruction
  // leaves no trace in the PC, IR, GRF or DM.
  always_comb begin
    pc_we   = pc_we_c  & ~reset;
    ir_we   = ir_we_c  & ~reset;
    reg_we  = reg_we_c & ~reset;
    mem_we  = mem_we_c & ~reset;
    npc_sel = npc_sel_c;
    reg_dst = reg_dst_c;
    wd_sel  = wd_sel_c;
    state   = state_q;
  end

  // An instruction retires when a legal non-FETCH state hands back to FETCH.
  always_comb begin
    retire = (state_q != S_FETCH) && (state_q <= S_WB) && (state_nxt == S_FETCH);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_nxt;
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)       instr_cnt <= 32'd0;
    else if (retire) instr_cnt <= instr_cnt + 32'd1;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [2:0]  state;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        ir_we;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [1:0]  ext_op;
  logic        mem_we;
  logic [31:0] instr_cnt;

  int ncmp  = 0;
  int nfail = 0;

  mc_ctrl #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .state(state), .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .alu_op(alu_op), .ext_op(ext_op), .mem_we(mem_we), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
  endtask

  // Compare every control output plus state, 1 time unit after the edge.
  task automatic chk_out(input string tag, input logic [2:0] st,
                         input logic pcwe, input logic [1:0] npc,
                         input logic irwe, input logic regwe,
                         input logic [1:0] dst, input logic [1:0] wd,
                         input logic src, input logic [2:0] op,
                         input logic [1:0] ext, input logic memwe);
    logic [18:0] obs;
    logic [18:0] expv;
    #1;
    obs  = {state, pc_we, npc_sel, ir_we, reg_we, reg_dst, wd_sel,
            alu_src, alu_op, ext_op, mem_we};
    expv = {st, pcwe, npc, irwe, regwe, dst, wd, src, op, ext, memwe};
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] expv);
    ncmp++;
    assert (instr_cnt === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instr_cnt, expv);
    end
  endtask

  // FETCH outputs with reset low: only pc_we/ir_we, npc_sel=0.
  task automatic chk_fetch(input string tag);
    chk_out(tag, 3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic chk_decode_idle(input string tag);
    chk_out(tag, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
  endtask

  // addu, subu, ori, lui: opcode, funct, alu_op, alu_src, ext_op, WB reg_dst
  logic [5:0] a_opc [4] = '{6'h00, 6'h00, 6'h0d, 6'h0f};
  logic [5:0] a_fn  [4] = '{6'h21, 6'h23, 6'h00, 6'h00};
  logic [2:0] a_op  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
  logic       a_src [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] a_ext [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
  logic [1:0] a_dst [4] = '{2'd1, 2'd1, 2'd0, 2'd0};

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;

    // Reset: FETCH, counter 0, enables held low while reset is high.
    tick(); tick();
    chk_out("reset_outputs", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    chk_cnt("reset_cnt", 32'd0);
    reset = 1'b0;

    // All-zero word: NOP class, 2 cycles.
    chk_fetch("nop_fetch");
    tick(); chk_decode_idle("nop_decode");
    tick(); chk_fetch("nop_back_fetch");
    chk_cnt("nop_cnt", 32'd1);

    // lw: 0,1,2,3,4,0.
    opcode = 6'h23; funct = 6'h00;
    tick(); chk_decode_idle("lw_decode");
    tick(); chk_out("lw_exec", 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    tick(); chk_out("lw_mem",  3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    tick(); chk_out("lw_wb",   3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 3'd0, 2'd1, 1'b0);
    chk_cnt("lw_cnt_before_retire", 32'd1);
    tick(); chk_fetch("lw_back_fetch");
    chk_cnt("lw_cnt", 32'd2);

    // beq taken then not taken, 3 cycles each.
    opcode = 6'h04; zero = 1'b1;
    tick(); chk_decode_idle("beq_t_decode");
    tick(); chk_out("beq_t_exec", 3'd2, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 2'd1, 1'b0);
    tick(); chk_fetch("beq_t_back_fetch");
    chk_cnt("beq_t_cnt", 32'd3);
    zero = 1'b0;
    tick(); chk_decode_idle("beq_n_decode");
    tick(); chk_out("beq_n_exec", 3'd2, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 2'd1, 1'b0);
    tick(); chk_fetch("beq_n_back_fetch");
    chk_cnt("beq_n_cnt", 32'd4);

    // jal, j, jr: 2 cycles each.
    opcode = 6'h03;
    tick(); chk_out("jal_decode", 3'd1, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 3'd0, 2'd0, 1'b0);
    tick(); chk_fetch("jal_back_fetch");
    opcode = 6'h02;
    tick(); chk_out("j_decode", 3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick(); chk_fetch("j_back_fetch");
    opcode = 6'h00; funct = 6'h08;
    tick(); chk_out("jr_decode", 3'd1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    tick(); chk_fetch("jr_back_fetch");
    chk_cnt("jumps_cnt", 32'd7);

    // Unknown opcode and unknown R-type funct behave as NOP.
    opcode = 6'h3f; funct = 6'h00;
    tick(); chk_decode_idle("bad_op_decode");
    tick(); chk_fetch("bad_op_back_fetch");
    opcode = 6'h00; funct = 6'h2a;
    tick(); chk_decode_idle("bad_fn_decode");
    tick(); chk_fetch("bad_fn_back_fetch");
    chk_cnt("nop_class_cnt", 32'd9);

    // sw with reset asserted during MEM: write suppressed, no retire.
    opcode = 6'h2b; funct = 6'h00;
    tick(); chk_decode_idle("sw_decode");
    tick(); chk_out("sw_exec", 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    tick(); chk_out("sw_mem", 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b1);
    reset = 1'b1;
    chk_out("sw_mem_reset", 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    tick();
    chk_out("sw_after_reset", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0);
    chk_cnt("sw_reset_cnt", 32'd0);
    reset = 1'b0;
    chk_fetch("post_reset_fetch");

    // addu, subu, ori, lui back to back: 4 cycles each.
    for (int i = 0; i < 4; i++) begin
      opcode = a_opc[i]; funct = a_fn[i];
      tick(); chk_decode_idle($sformatf("arith%0d_decode", i));
      tick(); chk_out($sformatf("arith%0d_exec", i), 3'd2, 1'b0, 2'd0, 1'b0, 1'b0,
                      2'd0, 2'd0, a_src[i], a_op[i], a_ext[i], 1'b0);
      tick(); chk_out($sformatf("arith%0d_wb", i), 3'd4, 1'b0, 2'd0, 1'b0, 1'b1,
                      a_dst[i], 2'd0, a_src[i], a_op[i], a_ext[i], 1'b0);
      tick(); chk_fetch($sformatf("arith%0d_back_fetch", i));
    end
    chk_cnt("arith_cnt", 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
